enemy_patrol: RTL and testbench

ENEMY_PATROL -- requirements
Module: enemy_patrol

---
 rtl/enemy_patrol_if.sv | 22 ++
 rtl/enemy_patrol.sv | 181 ++++++++++++++++++
 tb/tb_enemy_patrol.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/enemy_patrol_if.sv
// Signal bundle between an enemy_patrol instance and the game logic driving it.
// The game side (master) supplies level and spawn point; the enemy (slave) reports position and pose.
interface enemy_patrol_if;
   logic [5:0] level;
   logic [9:0] Enemy_X_Original;
   logic [9:0] Enemy_Y_Original;
   logic [9:0] EnemyX;
   logic [9:0] EnemyY;
   logic [2:0] state;
   logic [1:0] tilt;
   logic       arrived;

   modport master (
      output level, Enemy_X_Original, Enemy_Y_Original,
      input  EnemyX, EnemyY, state, tilt, arrived
   );

   modport slave (
      input  level, Enemy_X_Original, Enemy_Y_Original,
      output EnemyX, EnemyY, state, tilt, arrived
   );
endinterface

// File: rtl/enemy_patrol.sv
// Enemy sprite controller: flies in to a patrol row, bounces horizontally between screen limits,
// and with ENEMY_PATROL_DIVE_EN defined periodically dives to Y_DIVE and climbs back.
module enemy_patrol #(
   parameter int          HALF_W       = 120,
   parameter int          X_MIN        = 5,
   parameter int          X_MAX        = 639,
   parameter int          Y_TARGET     = 80,
   parameter int          Y_DIVE       = 200,
   parameter int          ENTRY_SPEED  = 1,
   parameter int          PATROL_SPEED = 2,
   parameter int          DIVE_SPEED   = 4,
   parameter logic [5:0]  ACTIVE_LEVEL = 6'b001000,
   parameter int          DIVE_PERIOD  = 256
) (
   input  logic            frame_clk,
   input  logic            Reset,
   enemy_patrol_if.slave   bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ENTER  = 3'd1;
   localparam logic [2:0] S_PATROL = 3'd2;
   localparam logic [2:0] S_DIVE   = 3'd3;
   localparam logic [2:0] S_RETURN = 3'd4;

   localparam logic [5:0]         START_LEVEL = 6'b000001;
   localparam logic [9:0]         X_LO   = 10'(X_MIN + HALF_W);
   localparam logic [9:0]         X_HI   = 10'(X_MAX - HALF_W);
   localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
   localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
   localparam logic signed [11:0] HW_S   = 12'(HALF_W);
   localparam logic signed [11:0] PS_S   = 12'(PATROL_SPEED);
   localparam logic signed [11:0] DS_S   = 12'(DIVE_SPEED);
   localparam logic signed [11:0] YT_S   = 12'(Y_TARGET);

   if (DIVE_PERIOD < 1 || X_MAX <= X_MIN + 2 * HALF_W) begin : g_param_check
      $error("enemy_patrol: inconsistent parameters");
   end

   logic [2:0] state_q, state_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic       dir_q, dir_d;          // 1 = moving right
   logic       arrived_q, arrived_d;

`ifdef ENEMY_PATROL_DIVE_EN
   localparam int            CW        = $clog2(DIVE_PERIOD + 1);
   localparam logic [CW-1:0] DIVE_LAST = CW'(DIVE_PERIOD - 1);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   // Boundary tests run in 12-bit signed so a small X moving left cannot wrap.
   logic signed [11:0] x_s, right_reach, left_reach, y_ret;
   logic [10:0]        y_enter, y_dive;
   logic [9:0]         pat_x;
   logic               pat_dir;

   always_comb begin
      x_s         = $signed({2'b00, x_q});
      right_reach = x_s + PS_S + HW_S;
      left_reach  = x_s - PS_S - HW_S;
      y_enter     = {1'b0, y_q} + 11'(ENTRY_SPEED);
      y_dive      = {1'b0, y_q} + 11'(DIVE_SPEED);
      y_ret       = $signed({2'b00, y_q}) - DS_S;
      pat_x       = x_q;
      pat_dir     = dir_q;
      if (dir_q) begin
         if (right_reach >= XMAX_S) begin
            pat_x   = X_HI;
            pat_dir = 1'b0;
         end else begin
            pat_x   = x_q + 10'(PATROL_SPEED);
         end
      end else begin
         if (left_reach <= XMIN_S) begin
            pat_x   = X_LO;
            pat_dir = 1'b1;
         end else begin
            pat_x   = x_q - 10'(PATROL_SPEED);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      dir_d     = dir_q;
      arrived_d = 1'b0;
`ifdef ENEMY_PATROL_DIVE_EN
      cnt_d     = cnt_q;
`endif
      if (bus.level == START_LEVEL) begin
         state_d = S_IDLE;
         x_d     = bus.Enemy_X_Original;
         y_d     = bus.Enemy_Y_Original;
         dir_d   = 1'b1;
`ifdef ENEMY_PATROL_DIVE_EN
         cnt_d   = '0;
`endif
      end else if (bus.level == ACTIVE_LEVEL) begin
         case (state_q)
            S_IDLE: begin
               x_d     = bus.Enemy_X_Original;
               y_d     = bus.Enemy_Y_Original;
               state_d = S_ENTER;
            end
            S_ENTER: begin
               if (y_enter >= 11'(Y_TARGET)) begin
                  y_d       = 10'(Y_TARGET);
                  state_d   = S_PATROL;
                  dir_d     = 1'b1;
                  arrived_d = 1'b1;
               end else begin
                  y_d = y_enter[9:0];
               end
            end
            S_PATROL: begin
`ifdef ENEMY_PATROL_DIVE_EN
               if (cnt_q == DIVE_LAST) begin
                  state_d = S_DIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  x_d   = pat_x;
                  dir_d = pat_dir;
               end
`else
               x_d   = pat_x;
               dir_d = pat_dir;
`endif
            end
            S_DIVE: begin
               if (y_dive >= 11'(Y_DIVE)) begin
                  y_d     = 10'(Y_DIVE);
                  state_d = S_RETURN;
               end else begin
                  y_d = y_dive[9:0];
               end
            end
            S_RETURN: begin
               if (y_ret <= YT_S) begin
                  y_d     = 10'(Y_TARGET);
                  state_d = S_PATROL;
               end else begin
                  y_d = y_ret[9:0];
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         x_q       <= bus.Enemy_X_Original;
         y_q       <= bus.Enemy_Y_Original;
         dir_q     <= 1'b1;
         arrived_q <= 1'b0;
`ifdef ENEMY_PATROL_DIVE_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_q     <= dir_d;
         arrived_q <= arrived_d;
`ifdef ENEMY_PATROL_DIVE_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign bus.EnemyX  = x_q;
   assign bus.EnemyY  = y_q;
   assign bus.state   = state_q;
   assign bus.arrived = arrived_q;
   assign bus.tilt    = (state_q == S_PATROL) ? (dir_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_enemy_patrol.sv
// Self-checking bench for enemy_patrol: a behavioural model predicts every frame into a scoreboard
// queue, plus directed checks on entry, wall bounces, freeze and reset.
module tb_enemy_patrol;

   localparam logic [5:0] ACT    = 6'b001000;
   localparam logic [5:0] START  = 6'b000001;
   localparam logic [5:0] FROZEN = 6'b000100;

   logic frame_clk = 1'b0;
   logic Reset;

   enemy_patrol_if bus ();

   enemy_patrol dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   always #5 frame_clk = ~frame_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [25:0] exp_q[$];

   // Reference model state
   int m_state, m_x, m_y, m_dir, m_cnt, m_arr;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (frame %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [25:0] model_pack();
      int t;
      t = (m_state == 2) ? (m_dir ? 2 : 1) : 0;
      return {3'(m_state), 10'(m_x), 10'(m_y), 2'(t), 1'(m_arr)};
   endfunction

   task automatic model_step(input logic rst, input logic [5:0] lvl, input int xo, input int yo);
      if (rst || lvl == START) begin
         m_state = 0; m_x = xo; m_y = yo; m_dir = 1; m_cnt = 0; m_arr = 0;
      end else if (lvl != ACT) begin
         m_arr = 0;
      end else begin
         m_arr = 0;
         case (m_state)
            0: begin m_x = xo; m_y = yo; m_state = 1; end
            1: begin
               if (m_y + 1 >= 80) begin m_y = 80; m_state = 2; m_dir = 1; m_arr = 1; end
               else m_y = m_y + 1;
            end
            2: begin
`ifdef ENEMY_PATROL_DIVE_EN
               if (m_cnt == 255) begin
                  m_state = 3; m_cnt = 0;
               end else begin
                  m_cnt = m_cnt + 1;
                  patrol_move();
               end
`else
               patrol_move();
`endif
            end
            3: begin
               m_y = (m_y + 4 >= 200) ? 200 : m_y + 4;
               if (m_y == 200) m_state = 4;
            end
            4: begin
               m_y = (m_y - 4 <= 80) ? 80 : m_y - 4;
               if (m_y == 80) m_state = 2;
            end
            default: m_state = 0;
         endcase
      end
   endtask

   task automatic patrol_move();
      if (m_dir == 1) begin
         if (m_x + 2 + 120 >= 639) begin m_x = 519; m_dir = 0; end
         else m_x = m_x + 2;
      end else begin
         if (m_x - 2 - 120 <= 5) begin m_x = 125; m_dir = 1; end
         else m_x = m_x - 2;
      end
   endtask

   task automatic drive_edge(input logic rst, input logic [5:0] lvl, input int xo, input int yo);
      logic [25:0] e;
      logic [25:0] a;
      Reset                = rst;
      bus.level            = lvl;
      bus.Enemy_X_Original = 10'(xo);
      bus.Enemy_Y_Original = 10'(yo);
      model_step(rst, lvl, xo, yo);
      exp_q.push_back(model_pack());
      @(posedge frame_clk);
      #1;
      cyc++;
      e = exp_q.pop_front();
      a = {bus.state, bus.EnemyX, bus.EnemyY, bus.tilt, bus.arrived};
      check_eq("sb", 32'(a), 32'(e));
   endtask

   int snap_x, snap_y, snap_state, out_of_range, y_off, max_y;

   initial begin
      // Reset with level forced to a non-start code shows reset wins.
      drive_edge(1'b1, START, 320, 0);
      drive_edge(1'b1, ACT, 320, 0);
      check_eq("rst_state", 32'(bus.state), 32'd0);
      check_eq("rst_x", 32'(bus.EnemyX), 32'd320);
      check_eq("rst_y", 32'(bus.EnemyY), 32'd0);
      check_eq("rst_tilt", 32'(bus.tilt), 32'd0);
      check_eq("rst_arrived", 32'(bus.arrived), 32'd0);

      // Entry: edge 1 to ENTER, edge 81 reaches the patrol row.
      drive_edge(1'b0, ACT, 320, 0);
      check_eq("enter_state", 32'(bus.state), 32'd1);
      check_eq("enter_y", 32'(bus.EnemyY), 32'd0);
      for (int i = 2; i <= 81; i++) drive_edge(1'b0, ACT, 320, 0);
      check_eq("arrive_y", 32'(bus.EnemyY), 32'd80);
      check_eq("arrive_state", 32'(bus.state), 32'd2);
      check_eq("arrive_pulse", 32'(bus.arrived), 32'd1);

      // Patrol right from 320 to the wall.
      drive_edge(1'b0, ACT, 320, 0);
      check_eq("arrive_pulse_end", 32'(bus.arrived), 32'd0);
      check_eq("patrol_first_x", 32'(bus.EnemyX), 32'd322);
      for (int i = 2; i <= 99; i++) drive_edge(1'b0, ACT, 320, 0);
      check_eq("patrol99_x", 32'(bus.EnemyX), 32'd518);
      drive_edge(1'b0, ACT, 320, 0);
      check_eq("patrol100_x", 32'(bus.EnemyX), 32'd519);
      check_eq("patrol100_tilt", 32'(bus.tilt), 32'd1);

      // Sweep left to the other wall and back.
      out_of_range = 0;
      for (int i = 0; i < 220; i++) begin
         drive_edge(1'b0, ACT, 320, 0);
         if (bus.state == 3'd2 && (bus.EnemyX < 10'd125 || bus.EnemyX > 10'd519)) out_of_range++;
      end
      check_eq("patrol_range", 32'(out_of_range), 32'd0);

      // Freeze for 10 frames, then resume.
      snap_x = m_x; snap_y = m_y; snap_state = m_state;
      for (int i = 0; i < 10; i++) drive_edge(1'b0, FROZEN, 320, 0);
      check_eq("freeze_x", 32'(bus.EnemyX), 32'(snap_x));
      check_eq("freeze_y", 32'(bus.EnemyY), 32'(snap_y));
      check_eq("freeze_state", 32'(bus.state), 32'(snap_state));
      for (int i = 0; i < 5; i++) drive_edge(1'b0, ACT, 320, 0);

      // Long patrol: Y stays on the row without dives, reaches Y_DIVE with them.
      y_off = 0; max_y = 0;
      for (int i = 0; i < 1000; i++) begin
         drive_edge(1'b0, ACT, 320, 0);
         if (bus.EnemyY != 10'd80) y_off++;
         if (int'(bus.EnemyY) > max_y) max_y = int'(bus.EnemyY);
      end
`ifdef ENEMY_PATROL_DIVE_EN
      check_eq("dive_depth", 32'(max_y), 32'd200);
`else
      check_eq("no_dive_y", 32'(y_off), 32'd0);
`endif

      // Reset taken mid-dive (or mid-patrol without dives).
      for (int i = 0; i < 400 && !(m_state == 3 && m_y == 140); i++) drive_edge(1'b0, ACT, 320, 0);
      drive_edge(1'b1, ACT, 300, 10);
      check_eq("midrst_state", 32'(bus.state), 32'd0);
      check_eq("midrst_x", 32'(bus.EnemyX), 32'd300);
      check_eq("midrst_y", 32'(bus.EnemyY), 32'd10);
      check_eq("midrst_tilt", 32'(bus.tilt), 32'd0);

      // Random level changes, spawn points and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [5:0] lvl;
         r = $urandom_range(0, 199);
         lvl = (r == 1) ? START : ((r >= 2 && r <= 5) ? FROZEN : ACT);
         drive_edge(r == 0, lvl, $urandom_range(0, 1023), $urandom_range(0, 300));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
